// File: rtl/mux_n_arb.sv
// N-input registered mux with per-channel valid/ready handshakes and a one-entry output register.
// A word is picked by round-robin, fixed priority or a forced select.
module mux_n_arb #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_IN   = 3,
    parameter bit          RR_EN  = 1'b1,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    input  logic                   force_en,
    input  logic [SEL_W-1:0]       force_sel,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_sel
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q,  out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              load_en_c;
    logic              gnt_any_c;
    logic [SEL_W-1:0]  gnt_idx_c;
    logic [N_IN-1:0]   grant_c;

    assign load_en_c = !out_valid_q || out_ready;

    // Grant selection; an out-of-range force_sel matches no channel and grants nothing.
    always_comb begin
        int unsigned c;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        c         = 0;
        if (force_en) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (SEL_W'(i) == force_sel && in_valid[SEL_W'(i)]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = SEL_W'(i);
                end
            end
        end else if (RR_EN) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                c = 32'(ptr_q) + k;
                if (c >= N_IN) begin
                    c = c - N_IN;
                end
                if (!gnt_any_c && in_valid[SEL_W'(c)]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = SEL_W'(c);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (!gnt_any_c && in_valid[SEL_W'(i)]) begin
                    gnt_any_c = 1'b1;
                    gnt_idx_c = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant_c = '0;
        if (gnt_any_c) begin
            grant_c[gnt_idx_c] = 1'b1;
        end
    end

    // Nothing is accepted while reset is held, even though the register reads empty.
    assign in_ready = grant_c & {N_IN{load_en_c && !arst}};

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en_c) begin
            if (gnt_any_c) begin
                out_data_d  = in_data[32'(gnt_idx_c)*DATA_W +: DATA_W];
                out_sel_d   = gnt_idx_c;
                out_valid_d = 1'b1;
                if (!force_en && RR_EN) begin
                    ptr_d = (gnt_idx_c == SEL_W'(N_IN-1)) ? '0 : gnt_idx_c + SEL_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_arb.sv
// Scoreboard bench for mux_n_arb: one round-robin instance and one fixed-priority instance.
module tb_mux_n_arb;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 3;
    localparam int unsigned SW = 2;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    logic [N*DW-1:0] rr_in_data, fp_in_data;
    logic [N-1:0]    rr_in_valid, fp_in_valid, rr_in_ready, fp_in_ready;
    logic            rr_force_en, fp_force_en;
    logic [SW-1:0]   rr_force_sel, fp_force_sel, rr_out_sel, fp_out_sel;
    logic [DW-1:0]   rr_out_data, fp_out_data;
    logic            rr_out_valid, fp_out_valid, rr_out_ready, fp_out_ready;

    mux_n_arb #(.DATA_W(DW), .N_IN(N), .RR_EN(1'b1)) u_rr (
        .clk(clk), .arst(arst), .in_data(rr_in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .force_en(rr_force_en), .force_sel(rr_force_sel),
        .out_data(rr_out_data), .out_valid(rr_out_valid), .out_ready(rr_out_ready),
        .out_sel(rr_out_sel)
    );

    mux_n_arb #(.DATA_W(DW), .N_IN(N), .RR_EN(1'b0)) u_fp (
        .clk(clk), .arst(arst), .in_data(fp_in_data), .in_valid(fp_in_valid),
        .in_ready(fp_in_ready), .force_en(fp_force_en), .force_sel(fp_force_sel),
        .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(fp_out_ready),
        .out_sel(fp_out_sel)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    function automatic logic [DW-1:0] word(input int s, input int c);
        return 16'hA000 + 16'((s % 256) * 16 + c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Apply one vector to the chosen instance, check in_ready, and queue the expected word.
    task automatic drive(input bit fp, input logic [2:0] valid, input logic fen,
                         input logic [1:0] fsel, input logic ordy, input logic [2:0] rdy);
        logic [N*DW-1:0] d;
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) d[i*DW +: DW] = word(seq, i);
        rr_in_valid = '0; rr_force_en = 1'b0; rr_force_sel = '0; rr_out_ready = 1'b1;
        fp_in_valid = '0; fp_force_en = 1'b0; fp_force_sel = '0; fp_out_ready = 1'b1;
        if (fp) begin
            fp_in_data = d; fp_in_valid = valid; fp_force_en = fen;
            fp_force_sel = fsel; fp_out_ready = ordy;
        end else begin
            rr_in_data = d; rr_in_valid = valid; rr_force_en = fen;
            rr_force_sel = fsel; rr_out_ready = ordy;
        end
        #1;
        check(fp ? "fp_in_ready" : "rr_in_ready", 32'(fp ? fp_in_ready : rr_in_ready), 32'(rdy));
        for (int i = 0; i < int'(N); i++) begin
            if (rdy[i]) begin
                e.data = word(seq, i);
                e.sel  = SW'(i);
                if (fp) q_fp.push_back(e);
                else    q_rr.push_back(e);
            end
        end
        seq++;
    endtask

    // Assert reset, check the cleared state at once, then release with inputs idle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        arst = 1'b1;
        rr_in_valid = 3'b111; fp_in_valid = 3'b111;
        rr_force_en = 1'b0;   fp_force_en = 1'b0;
        #1;
        check("rst_out_valid", 32'(rr_out_valid), 32'd0);
        check("rst_out_data",  32'(rr_out_data),  32'd0);
        check("rst_out_sel",   32'(rr_out_sel),   32'd0);
        check("rst_in_ready",  32'(rr_in_ready),  32'd0);
        check("rst_fp_valid",  32'(fp_out_valid), 32'd0);
        check("rst_fp_ready",  32'(fp_in_ready),  32'd0);
        q_rr.delete();
        q_fp.delete();
        rr_in_valid = '0; fp_in_valid = '0;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    // Output monitors: every accepted output word must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (!arst && rr_out_valid === 1'b1 && rr_out_ready === 1'b1) begin
            if (q_rr.size() == 0) begin
                checks++; errors++;
                $display("FAIL rr_dup: got word %0h sel %0d expected no word", rr_out_data, rr_out_sel);
            end else begin
                e = q_rr.pop_front();
                check("rr_out_data", 32'(rr_out_data), 32'(e.data));
                check("rr_out_sel",  32'(rr_out_sel),  32'(e.sel));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!arst && fp_out_valid === 1'b1 && fp_out_ready === 1'b1) begin
            if (q_fp.size() == 0) begin
                checks++; errors++;
                $display("FAIL fp_dup: got word %0h sel %0d expected no word", fp_out_data, fp_out_sel);
            end else begin
                e = q_fp.pop_front();
                check("fp_out_data", 32'(fp_out_data), 32'(e.data));
                check("fp_out_sel",  32'(fp_out_sel),  32'(e.sel));
            end
        end
    end

    initial begin
        rr_in_data = '0; rr_in_valid = '0; rr_force_en = 1'b0; rr_force_sel = '0; rr_out_ready = 1'b1;
        fp_in_data = '0; fp_in_valid = '0; fp_force_en = 1'b0; fp_force_sel = '0; fp_out_ready = 1'b1;
        do_reset();

        // Round-robin with all channels valid
        drive(0, 3'b111, 0, 2'd0, 1, 3'b001);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b010);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b100);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b001);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b010);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b100);
        // Backpressure: held word, nothing accepted, then RR resumes at ptr=0
        for (int i = 0; i < 4; i++) drive(0, 3'b111, 0, 2'd0, 0, 3'b000);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b001);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b010);
        // Force: idle target, out-of-range target, valid target, then ptr still 2
        drive(0, 3'b011, 1, 2'd2, 1, 3'b000);
        drive(0, 3'b111, 1, 2'd3, 1, 3'b000);
        drive(0, 3'b111, 1, 2'd0, 1, 3'b001);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b100);
        // Sparse single pulse on channel 1
        drive(0, 3'b000, 0, 2'd0, 1, 3'b000);
        drive(0, 3'b010, 0, 2'd0, 1, 3'b010);
        for (int i = 0; i < 3; i++) drive(0, 3'b000, 0, 2'd0, 1, 3'b000);
        // Wrap from ptr=2 with channel 2 idle
        drive(0, 3'b011, 0, 2'd0, 1, 3'b001);
        drive(0, 3'b011, 0, 2'd0, 1, 3'b010);
        drive(0, 3'b011, 0, 2'd0, 1, 3'b001);
        // Reset mid-stream discards the held word and restarts at ptr=0
        drive(0, 3'b111, 0, 2'd0, 1, 3'b010);
        do_reset();
        drive(0, 3'b111, 0, 2'd0, 1, 3'b001);
        drive(0, 3'b111, 0, 2'd0, 1, 3'b010);
        drive(0, 3'b000, 0, 2'd0, 1, 3'b000);
        drive(0, 3'b000, 0, 2'd0, 1, 3'b000);

        // Fixed priority instance
        drive(1, 3'b110, 0, 2'd0, 1, 3'b010);
        drive(1, 3'b110, 0, 2'd0, 1, 3'b010);
        drive(1, 3'b110, 0, 2'd0, 1, 3'b010);
        drive(1, 3'b100, 0, 2'd0, 1, 3'b100);
        drive(1, 3'b111, 0, 2'd0, 1, 3'b001);
        drive(1, 3'b111, 0, 2'd0, 0, 3'b000);
        drive(1, 3'b011, 0, 2'd0, 1, 3'b001);
        drive(1, 3'b000, 0, 2'd0, 1, 3'b000);
        drive(1, 3'b000, 0, 2'd0, 1, 3'b000);
        repeat (2) @(posedge clk);

        check("rr_queue_empty", 32'(q_rr.size()), 32'd0);
        check("fp_queue_empty", 32'(q_fp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
